// File: rtl/rf_pkg.sv
// rf_pkg: shared types and constants for the register-file write scheduler.
package rf_pkg;
  localparam int NUM_REGS = 32;
  typedef logic [4:0] reg_idx_t;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {RESET_HOLD, CLEAR, RUN} state_t;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-input round-robin arbiter, pointer moves only on a grant.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  output logic [1:0] grant
);
  logic last;
  // last=1 means requester 1 was granted most recently, so requester 0 wins a tie
  always_comb grant = &valid ? (last ? 2'b01 : 2'b10) : valid;
  always_ff @(posedge clk) begin
    if (rst) last <= 1'b1;
    else if (|grant) last <= grant[1];
  end
endmodule

// File: rtl/rf_write_scheduler.sv
// rf_write_scheduler: clears the register file after reset, then arbitrates two writeback ports.
module rf_write_scheduler
  import rf_pkg::*;
#(
  parameter bit CLEAR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [4:0]  req0_sel,
  input  logic [31:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [4:0]  req1_sel,
  input  logic [31:0] req1_data,
  output logic        req1_ready,
  output logic [4:0]  wsel,
  output logic [31:0] wdata,
  output logic        wen,
  output logic        init_done,
  output logic        drop_x0
);
  localparam reg_idx_t LAST_IDX = reg_idx_t'(NUM_REGS - 1);
  state_t state, state_n;
  reg_idx_t cnt, xsel;
  word_t xdata;
  logic [1:0] grant;
  logic run, xfer, clr_wr;
  // rst gates grants so no request is consumed on an aborting edge
  assign run = state == RUN && !rst;
  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .valid ({req1_valid, req0_valid} & {2{run}}),
    .grant (grant)
  );
  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign init_done = state == RUN;
  assign xfer = |grant;
  assign xsel = grant[1] ? req1_sel : req0_sel;
  assign xdata = grant[1] ? req1_data : req0_data;
  // the counter wraps to 0 after the index-31 write; one more CLEAR cycle shows that write
  assign clr_wr = state == CLEAR && cnt != '0;
  always_comb begin
    state_n = state;
    if (state == RESET_HOLD) state_n = CLEAR_EN ? CLEAR : RUN;
    else if (state == CLEAR && cnt == '0) state_n = RUN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RESET_HOLD;
      cnt <= 5'd1;
      wen <= 1'b0;
      wsel <= '0;
      wdata <= '0;
      drop_x0 <= 1'b0;
    end else begin
      state <= state_n;
      if (state == CLEAR) cnt <= cnt == LAST_IDX ? '0 : cnt + 5'd1;
      wen <= clr_wr || (xfer && xsel != '0);
      drop_x0 <= xfer && xsel == '0;
      if (clr_wr) begin
        wsel <= cnt;
        wdata <= '0;
      end else if (xfer && xsel != '0) begin
        wsel <= xsel;
        wdata <= xdata;
      end
    end
  end
endmodule
